// File: rtl/tsp16_pkg.sv
// Shared definitions for the operand fetch stage: default widths and the fetch FSM encoding.
package tsp16_pkg;

    localparam int TSP16_DATA_W = 16;
    localparam int TSP16_REG_AW = 3;
    localparam int TSP16_OP_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        HOLD   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode -> fetch -> execute handshake bundle. The fetch stage sits on the slave modport.
interface operand_fetch_if
    import tsp16_pkg::*;
#(
    parameter int DATA_W = TSP16_DATA_W,
    parameter int REG_AW = TSP16_REG_AW,
    parameter int OP_W   = TSP16_OP_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [REG_AW-1:0] in_rs_a;
    logic [REG_AW-1:0] in_rs_b;
    logic [REG_AW-1:0] in_rd;

    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_op;
    logic [REG_AW-1:0] out_rd;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;

    modport slave (
        input  in_valid, in_op, in_rs_a, in_rs_b, in_rd, out_ready,
        output in_ready, out_valid, out_op, out_rd, out_a, out_b
    );

    modport master (
        output in_valid, in_op, in_rs_a, in_rs_b, in_rd, out_ready,
        input  in_ready, out_valid, out_op, out_rd, out_a, out_b
    );

endinterface

// File: rtl/operand_bypass.sv
// Forwards same-cycle writeback data over the register-file read data when the
// register being read is also the one being written.
module operand_bypass
    import tsp16_pkg::*;
#(
    parameter int DATA_W = TSP16_DATA_W,
    parameter int REG_AW = TSP16_REG_AW
) (
    input  logic [REG_AW-1:0] sel_reg,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              wb_write,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    assign data = (wb_write && (wb_reg == sel_reg)) ? wb_data : rf_data;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two source registers through a single register-file
// read port, one per cycle, and presents the operand bundle to execute.
module operand_fetch
    import tsp16_pkg::*;
#(
    parameter int DATA_W = TSP16_DATA_W,
    parameter int REG_AW = TSP16_REG_AW,
    parameter int OP_W   = TSP16_OP_W
) (
    input  logic              clk,
    input  logic              reset,
    operand_fetch_if.slave    fetch,
    output logic [REG_AW-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    input  logic              wb_write,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush
);

    fetch_state_e      state_reg, state_next;
    logic [OP_W-1:0]   op_reg;
    logic [REG_AW-1:0] rs_a_reg, rs_b_reg, rd_reg;

    logic              ready;
    logic              valid;
    logic              accept;
    logic              same_src;
    logic [1:0]        capture_en;
    logic [DATA_W-1:0] bypass_data;
    logic [REG_AW-1:0] src_sel     [2];
    logic [DATA_W-1:0] operand_val [2];

    assign same_src   = (rs_a_reg == rs_b_reg);
    assign src_sel[0] = rs_a_reg;
    assign src_sel[1] = rs_b_reg;

    // Outside READ_B the port parks on rs_a so the select is always defined.
    assign rf_read_reg = (state_reg == READ_B) ? rs_b_reg : rs_a_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        valid      = 1'b0;
        capture_en = 2'b00;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (fetch.in_valid) state_next = READ_A;
            end
            READ_A: begin
                capture_en = same_src ? 2'b11 : 2'b01;
                state_next = same_src ? HOLD : READ_B;
            end
            READ_B: begin
                capture_en = 2'b10;
                state_next = HOLD;
            end
            HOLD: begin
                valid = 1'b1;
                ready = fetch.out_ready;
                if (fetch.out_ready) state_next = fetch.in_valid ? READ_A : IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A flush wins over every transition, including a same-cycle accept.
        if (flush) state_next = IDLE;
    end

    assign accept = fetch.in_valid && ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg   <= '0;
            rs_a_reg <= '0;
            rs_b_reg <= '0;
            rd_reg   <= '0;
        end else if (accept) begin
            op_reg   <= fetch.in_op;
            rs_a_reg <= fetch.in_rs_a;
            rs_b_reg <= fetch.in_rs_b;
            rd_reg   <= fetch.in_rd;
        end
    end

    operand_bypass #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_bypass (
        .sel_reg  (rf_read_reg),
        .rf_data  (rf_read_data),
        .wb_write (wb_write),
        .wb_reg   (wb_reg),
        .wb_data  (wb_data),
        .data     (bypass_data)
    );

    // Operand 0 is out_a (rs_a), operand 1 is out_b (rs_b).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic [DATA_W-1:0] value_reg;
            logic              refresh_en;

            // A held bundle tracks writebacks to its sources until it is consumed.
            assign refresh_en = valid && !fetch.out_ready && wb_write && (wb_reg == src_sel[gi]);

            always_ff @(posedge clk) begin
                if (reset) begin
                    value_reg <= '0;
                end else if (capture_en[gi]) begin
                    value_reg <= bypass_data;
                end else if (refresh_en) begin
                    value_reg <= wb_data;
                end
            end

            assign operand_val[gi] = value_reg;
        end
    endgenerate

    assign fetch.in_ready  = ready;
    assign fetch.out_valid = valid;
    assign fetch.out_op    = op_reg;
    assign fetch.out_rd    = rd_reg;
    assign fetch.out_a     = operand_val[0];
    assign fetch.out_b     = operand_val[1];

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a small register-file model feeds the read
// port, expected bundles are queued at issue and compared when out_valid appears.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        wb_write;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic [2:0]  rf_read_reg;
    logic [15:0] rf_read_data;
    logic [15:0] rf [8];

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    operand_fetch_if #(.DATA_W(16), .REG_AW(3), .OP_W(4)) bus ();

    operand_fetch #(.DATA_W(16), .REG_AW(3), .OP_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch        (bus),
        .rf_read_reg  (rf_read_reg),
        .rf_read_data (rf_read_data),
        .wb_write     (wb_write),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wb_write) rf[wb_reg] <= wb_data;
    assign rf_read_data = rf[rf_read_reg];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [2:0] r, input logic [15:0] d);
        wb_write = 1'b1; wb_reg = r; wb_data = d;
        tick();
        wb_write = 1'b0;
    endtask

    // Drives one instruction for a single cycle; caller ensures the stage is idle.
    task automatic issue(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] rd);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_rs_a = a; bus.in_rs_b = b; bus.in_rd = rd;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Returns the cycle index (relative to accept) at which out_valid is seen, or -1.
    task automatic wait_valid(input int start, output int n);
        n = start;
        for (int i = 0; i < 10; i++) begin
            n++;
            @(negedge clk);
            if (bus.out_valid) return;
            @(posedge clk);
            #1;
        end
        n = -1;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; wb_write = 1'b0; wb_reg = '0; wb_data = '0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_op = 4'hF; bus.in_rs_a = 3'd7; bus.in_rs_b = 3'd6; bus.in_rd = 3'd5;
        for (int r = 0; r < 8; r++) rf_write(r[2:0], 16'h0000);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_a !== 16'h0) begin failures++; $display("FAIL reset_out_a got=%h exp=0000", bus.out_a); end
        checks++; if (bus.out_b !== 16'h0) begin failures++; $display("FAIL reset_out_b got=%h exp=0000", bus.out_b); end
        checks++; if (bus.out_op !== 4'h0) begin failures++; $display("FAIL reset_out_op got=%h exp=0", bus.out_op); end
        checks++; if (bus.out_rd !== 3'h0) begin failures++; $display("FAIL reset_out_rd got=%h exp=0", bus.out_rd); end
        checks++; if (rf_read_reg !== 3'h0) begin failures++; $display("FAIL reset_rf_read_reg got=%h exp=0", rf_read_reg); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_basic();
        exp_t e; int n;
        rf_write(3'd1, 16'h1111);
        rf_write(3'd2, 16'h2222);
        sb.push_back('{op: 4'd3, rd: 3'd5, a: 16'h1111, b: 16'h2222, lat: 3});
        issue(4'd3, 3'd1, 3'd2, 3'd5);
        wait_valid(0, n);
        e = sb.pop_front();
        $display("basic bundle op=%h rd=%h a=%h b=%h lat=%0d", bus.out_op, bus.out_rd, bus.out_a, bus.out_b, n);
        checks++; if (n != e.lat) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", n, e.lat); end
        checks++; if (bus.out_a !== e.a) begin failures++; $display("FAIL basic_out_a got=%h exp=%h", bus.out_a, e.a); end
        checks++; if (bus.out_b !== e.b) begin failures++; $display("FAIL basic_out_b got=%h exp=%h", bus.out_b, e.b); end
        checks++; if (bus.out_rd !== e.rd) begin failures++; $display("FAIL basic_out_rd got=%h exp=%h", bus.out_rd, e.rd); end
        checks++; if (bus.out_op !== e.op) begin failures++; $display("FAIL basic_out_op got=%h exp=%h", bus.out_op, e.op); end
        consume();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drop_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_same_reg();
        exp_t e; int n;
        rf_write(3'd4, 16'h00FF);
        sb.push_back('{op: 4'd1, rd: 3'd2, a: 16'h00FF, b: 16'h00FF, lat: 2});
        issue(4'd1, 3'd4, 3'd4, 3'd2);
        wait_valid(0, n);
        e = sb.pop_front();
        $display("same_reg bundle op=%h rd=%h a=%h b=%h lat=%0d", bus.out_op, bus.out_rd, bus.out_a, bus.out_b, n);
        checks++; if (n != e.lat) begin failures++; $display("FAIL same_latency got=%0d exp=%0d", n, e.lat); end
        checks++; if (bus.out_a !== e.a) begin failures++; $display("FAIL same_out_a got=%h exp=%h", bus.out_a, e.a); end
        checks++; if (bus.out_b !== e.b) begin failures++; $display("FAIL same_out_b got=%h exp=%h", bus.out_b, e.b); end
        consume();
    endtask

    task automatic test_bypass();
        exp_t e; int n;
        sb.push_back('{op: 4'd5, rd: 3'd7, a: 16'h1111, b: 16'hBEEF, lat: 3});
        issue(4'd5, 3'd1, 3'd2, 3'd7);
        tick();
        wb_write = 1'b1; wb_reg = 3'd2; wb_data = 16'hBEEF;
        tick();
        wb_write = 1'b0;
        wait_valid(2, n);
        e = sb.pop_front();
        $display("bypass bundle op=%h rd=%h a=%h b=%h lat=%0d", bus.out_op, bus.out_rd, bus.out_a, bus.out_b, n);
        checks++; if (n != e.lat) begin failures++; $display("FAIL bypass_latency got=%0d exp=%0d", n, e.lat); end
        checks++; if (bus.out_a !== e.a) begin failures++; $display("FAIL bypass_out_a got=%h exp=%h", bus.out_a, e.a); end
        checks++; if (bus.out_b !== e.b) begin failures++; $display("FAIL bypass_out_b got=%h exp=%h", bus.out_b, e.b); end
        consume();
    endtask

    task automatic test_hold_refresh();
        exp_t e; int n;
        sb.push_back('{op: 4'd6, rd: 3'd3, a: 16'h1111, b: 16'hBEEF, lat: 3});
        issue(4'd6, 3'd1, 3'd2, 3'd3);
        wait_valid(0, n);
        e = sb.pop_front();
        $display("refresh bundle op=%h rd=%h a=%h b=%h lat=%0d", bus.out_op, bus.out_rd, bus.out_a, bus.out_b, n);
        checks++; if (bus.out_a !== e.a) begin failures++; $display("FAIL refresh_initial_a got=%h exp=%h", bus.out_a, e.a); end
        wb_write = 1'b1; wb_reg = 3'd1; wb_data = 16'h1234;
        tick();
        wb_write = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL refresh_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_a !== 16'h1234) begin failures++; $display("FAIL refresh_out_a got=%h exp=1234", bus.out_a); end
        checks++; if (bus.out_b !== e.b) begin failures++; $display("FAIL refresh_out_b got=%h exp=%h", bus.out_b, e.b); end
        // Writeback in the consuming cycle must not touch the departing bundle.
        bus.out_ready = 1'b1; wb_write = 1'b1; wb_reg = 3'd2; wb_data = 16'h5555;
        tick();
        wb_write = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL refresh_consumed_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_b !== e.b) begin failures++; $display("FAIL refresh_no_update_b got=%h exp=%h", bus.out_b, e.b); end
    endtask

    task automatic test_back_to_back();
        exp_t e; int v[$]; int acc; int diff;
        rf_write(3'd3, 16'h3333);
        rf_write(3'd6, 16'h6666);
        bus.out_ready = 1'b1;
        acc = -1;
        sb.push_back('{op: 4'd2, rd: 3'd4, a: 16'h1234, b: 16'h5555, lat: 3});
        sb.push_back('{op: 4'd7, rd: 3'd1, a: 16'h3333, b: 16'h6666, lat: 3});
        issue(4'd2, 3'd1, 3'd2, 3'd4);
        bus.in_valid = 1'b1; bus.in_op = 4'd7; bus.in_rs_a = 3'd3; bus.in_rs_b = 3'd6; bus.in_rd = 3'd1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                v.push_back(c);
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected_bundle got=a:%h exp=none", bus.out_a);
                end else begin
                    e = sb.pop_front();
                    $display("b2b bundle op=%h rd=%h a=%h b=%h cycle=%0d", bus.out_op, bus.out_rd, bus.out_a, bus.out_b, c);
                    if (bus.out_a !== e.a || bus.out_b !== e.b || bus.out_op !== e.op || bus.out_rd !== e.rd) begin
                        failures++;
                        $display("FAIL b2b_bundle got=%h/%h/%h/%h exp=%h/%h/%h/%h", bus.out_op, bus.out_rd, bus.out_a, bus.out_b, e.op, e.rd, e.a, e.b);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) acc = c;
            @(posedge clk);
            #1;
            if (acc == c) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        diff = (v.size() == 2) ? (v[1] - v[0]) : -1;
        checks++; if (v.size() != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", v.size()); end
        checks++; if (diff != 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=3", diff); end
        checks++; if (v.size() == 0 || v[0] != 3) begin failures++; $display("FAIL b2b_first_cycle got=%0d exp=3", (v.size() == 0) ? -1 : v[0]); end
        checks++; if (v.size() == 0 || acc != v[0]) begin failures++; $display("FAIL b2b_accept_in_hold got=%0d exp=3", acc); end
    endtask

    task automatic test_flush_reset();
        logic seen;
        issue(4'd1, 3'd1, 3'd2, 3'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        // A handshake presented together with flush is dropped as well.
        bus.in_valid = 1'b1; bus.in_op = 4'd9; bus.in_rs_a = 3'd3; bus.in_rs_b = 3'd6; bus.in_rd = 3'd2;
        flush = 1'b1;
        tick();
        bus.in_valid = 1'b0; flush = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            seen |= bus.out_valid;
            tick();
        end
        $display("flush window out_valid_seen=%b", seen);
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_valid got=%b exp=0", seen); end
        issue(4'd2, 3'd3, 3'd6, 3'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_a !== 16'h0) begin failures++; $display("FAIL rst_mid_out_a got=%h exp=0000", bus.out_a); end
        checks++; if (bus.out_b !== 16'h0) begin failures++; $display("FAIL rst_mid_out_b got=%h exp=0000", bus.out_b); end
        checks++; if (bus.out_op !== 4'h0) begin failures++; $display("FAIL rst_mid_out_op got=%h exp=0", bus.out_op); end
        checks++; if (bus.out_rd !== 3'h0) begin failures++; $display("FAIL rst_mid_out_rd got=%h exp=0", bus.out_rd); end
        checks++; if (rf_read_reg !== 3'h0) begin failures++; $display("FAIL rst_mid_rf_read_reg got=%h exp=0", rf_read_reg); end
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clk);
            seen |= bus.out_valid;
            tick();
        end
        $display("reset window out_valid_seen=%b", seen);
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_valid got=%b exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_reg();
        test_bypass();
        test_hold_refresh();
        test_back_to_back();
        test_flush_reset();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
